// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status constants, running-status kinds and the note event payload.
package midi_pkg;

  // Status high nibbles the parser cares about
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] SYS      = 4'hF;

  // Width of one buffered note event
  localparam int unsigned EV_W = 15;

  // What the data bytes following the current running status mean
  typedef enum logic [1:0] {
    RS_NOTE_OFF = 2'd0,
    RS_NOTE_ON  = 2'd1,
    RS_SKIP1    = 2'd2,
    RS_SKIP2    = 2'd3
  } rs_kind_t;

  // Running status register contents
  typedef struct packed {
    logic     valid;
    rs_kind_t kind;
    logic     match;
  } rs_t;

  // Note event as seen by the voice/display logic
  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } note_ev_t;

  // Map a channel-voice status nibble (8..E) to its running-status kind
  function automatic rs_kind_t status_kind(input logic [3:0] hi);
    rs_kind_t k;
    case (hi)
      NOTE_OFF:   k = RS_NOTE_OFF;
      NOTE_ON:    k = RS_NOTE_ON;
      4'hC, 4'hD: k = RS_SKIP1;
      default:    k = RS_SKIP2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// midi_event_fifo: small synchronous FIFO; a push into a full FIFO is only taken with a pop.
module midi_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  // DEPTH must be a power of two, at least 2
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/midi_note_sequencer.sv
// midi_note_sequencer: MIDI byte parser with running status and channel filter,
// turning Note On/Off messages into events buffered for the voice/display logic.
module midi_note_sequencer
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned TIMEOUT = 3840,
  parameter int unsigned DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_on,
  output logic [6:0] ev_note,
  output logic [6:0] ev_vel,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t           state;
  rs_t              rs;
  logic [6:0]       d1;
  logic [CNT_W-1:0] idle_cnt;

  logic     is_rt_c;
  logic     strobe_c;
  logic     is_status_c;
  logic     is_data_c;
  logic     note_kind_c;
  logic     ev_push_c;
  note_ev_t ev_in_c;
  note_ev_t ev_head;
  logic     fifo_full;
  logic     fifo_empty;

  // Classify the incoming strobe: byte_err wins, real-time bytes are invisible
  assign is_rt_c     = (byte_data[7:3] == 5'b11111);
  assign strobe_c    = byte_valid && !byte_err && !is_rt_c;
  assign is_status_c = strobe_c && byte_data[7];
  assign is_data_c   = strobe_c && !byte_data[7];
  assign note_kind_c = (rs.kind == RS_NOTE_ON) || (rs.kind == RS_NOTE_OFF);

  // Second data byte of a matching note message completes an event this cycle
  assign ev_push_c = is_data_c && (state == WAIT_D2) && rs.valid && rs.match && note_kind_c;

  // Event payload; a Note On with zero velocity is reported as a note off
  always_comb begin
    ev_in_c.on   = (rs.kind == RS_NOTE_ON) && (byte_data[6:0] != 7'd0);
    ev_in_c.note = d1;
    ev_in_c.vel  = byte_data[6:0];
  end

  // Parser: running status, data byte assembly, error recovery and inter-byte timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rs       <= '0;
      d1       <= '0;
      idle_cnt <= '0;
    end else if (byte_err) begin
      state    <= rs.valid ? WAIT_D1 : IDLE;
      idle_cnt <= '0;
    end else if (is_status_c) begin
      idle_cnt <= '0;
      if (byte_data[7:4] == SYS) begin
        rs.valid <= 1'b0;
        state    <= IDLE;
      end else begin
        rs.valid <= 1'b1;
        rs.kind  <= status_kind(byte_data[7:4]);
        rs.match <= (byte_data[3:0] == 4'(CHANNEL));
        state    <= WAIT_D1;
      end
    end else if (is_data_c) begin
      idle_cnt <= '0;
      case (state)
        WAIT_D1: begin
          if (rs.kind != RS_SKIP1) begin
            d1    <= byte_data[6:0];
            state <= WAIT_D2;
          end
        end
        WAIT_D2: state <= WAIT_D1;
        default: ;
      endcase
    end else if (state == WAIT_D2) begin
      if (idle_cnt == CNT_LAST) begin
        state    <= WAIT_D1;
        d1       <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

  // Flag a completed event lost because the FIFO was full with no pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else begin
      overflow <= ev_push_c && fifo_full && !ev_ready;
    end
  end

  midi_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_push_c),
    .din   (ev_in_c),
    .pop   (ev_ready),
    .dout  (ev_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_on    = ev_head.on;
  assign ev_note  = ev_head.note;
  assign ev_vel   = ev_head.vel;
  assign busy     = (state == WAIT_D2);

endmodule

// File: tb/tb_midi_note_sequencer.sv
// tb_midi_note_sequencer: directed scenarios plus randomized byte traffic against a reference model.
module tb_midi_note_sequencer;

  localparam int unsigned CHANNEL = 0;
  localparam int unsigned TIMEOUT = 3840;
  localparam int unsigned DEPTH   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [6:0] ev_note;
  logic [6:0] ev_vel;
  logic       overflow;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message interpreter plus an ideal bounded event queue
  int          m_phase;   // 0: no message, 1: expecting first data, 2: expecting second data
  int          m_quiet;
  bit          m_rs_valid;
  bit          m_match;
  logic [3:0]  m_hi;
  logic [6:0]  m_d1;
  logic [14:0] exp_q[$];
  bit          exp_ovf;

  always #5 clk = ~clk;

  midi_note_sequencer #(
    .CHANNEL (CHANNEL),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_on      (ev_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic model_reset();
    m_phase    = 0;
    m_quiet    = 0;
    m_rs_valid = 0;
    m_match    = 0;
    m_hi       = 4'h0;
    m_d1       = 7'h0;
    exp_q.delete();
    exp_ovf    = 0;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    byte_data  = 8'h00;
    ev_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Drive one clock of inputs, advance the model, return at the following falling edge
  task automatic step(input bit bv, input logic [7:0] bd, input bit be, input bit rdy);
    bit          gen;
    bit          popped;
    logic [14:0] ev;
    gen        = 0;
    ev         = '0;
    byte_valid = bv;
    byte_data  = bd;
    byte_err   = be;
    ev_ready   = rdy;
    popped     = rdy && (exp_q.size() != 0);
    if (be) begin
      m_phase = m_rs_valid ? 1 : 0;
      m_quiet = 0;
    end else if (bv && (bd < 8'hF8)) begin
      m_quiet = 0;
      if (bd >= 8'hF0) begin
        m_rs_valid = 0;
        m_phase    = 0;
      end else if (bd >= 8'h80) begin
        m_rs_valid = 1;
        m_hi       = bd[7:4];
        m_match    = (bd[3:0] == 4'(CHANNEL));
        m_phase    = 1;
      end else if (m_phase == 1) begin
        if ((m_hi != 4'hC) && (m_hi != 4'hD)) begin
          m_d1    = bd[6:0];
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 1;
        if (m_match && ((m_hi == 4'h8) || (m_hi == 4'h9))) begin
          gen = 1;
          ev  = {(m_hi == 4'h9) && (bd[6:0] != 7'd0), m_d1, bd[6:0]};
        end
      end
    end else if (m_phase == 2) begin
      m_quiet++;
      if (m_quiet == int'(TIMEOUT)) begin
        m_phase = 1;
        m_quiet = 0;
      end
    end
    if (popped) void'(exp_q.pop_front());
    exp_ovf = 0;
    if (gen) begin
      if (exp_q.size() < int'(DEPTH)) exp_q.push_back(ev);
      else exp_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_err   = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    apply_reset();
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    n_cmp++; if (got !== 15'h0) begin n_bad++; $display("FAIL reset_ev_fields: got %h want 0000", got); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_note_on();
    logic [14:0] got;
    logic [14:0] want;
    want = {1'b1, 7'h3C, 7'h64};
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL note_on_busy: got %b want 1", busy); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL note_on_early: got %b want 0", ev_valid); end
    step(1, 8'h64, 0, 0);
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL note_on_valid: got %b want 1", ev_valid); end
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL note_on_event: got %h want %h", got, want); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL note_on_idle: got %b want 0", busy); end
    step(0, 8'h00, 0, 1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL note_on_drain: got %b want 0", ev_valid); end
  endtask

  task automatic test_running_status();
    logic [14:0] got;
    logic [14:0] want1;
    logic [14:0] want2;
    want1 = {1'b1, 7'h3C, 7'h64};
    want2 = {1'b0, 7'h40, 7'h00};
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(1, 8'h64, 0, 0);
    step(1, 8'h40, 0, 0);
    step(1, 8'h00, 0, 0);
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (got !== want1) begin n_bad++; $display("FAIL rs_first: got %h want %h", got, want1); end
    step(0, 8'h00, 0, 1);
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (ev_valid !== 1'b1) begin n_bad++; $display("FAIL rs_second_valid: got %b want 1", ev_valid); end
    n_cmp++; if (got !== want2) begin n_bad++; $display("FAIL rs_second: got %h want %h", got, want2); end
    step(0, 8'h00, 0, 1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rs_drain: got %b want 0", ev_valid); end
  endtask

  task automatic test_filter_skip();
    logic [7:0] seq [8];
    seq = '{8'h91, 8'h3C, 8'h64, 8'hC0, 8'h05, 8'hB0, 8'h07, 8'h7F};
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0, 1);
      if (i == 4) begin
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL skip1_stays_d1: got %b want 0", busy); end
      end
    end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL filter_no_event: got %b want 0", ev_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL filter_busy: got %b want 0", busy); end
    step(1, 8'h11, 0, 1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL filter_ends_wait_d1: got %b want 1", busy); end
  endtask

  task automatic test_realtime();
    logic [14:0] got;
    logic [14:0] want;
    want = {1'b1, 7'h3C, 7'h64};
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(1, 8'hF8, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'hFE, 0, 0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rt_keeps_partial: got %b want 1", busy); end
    step(1, 8'h64, 0, 0);
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (got !== want || ev_valid !== 1'b1) begin n_bad++; $display("FAIL rt_event: got %b/%h want 1/%h", ev_valid, got, want); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_timeout();
    logic [14:0] got;
    logic [14:0] want;
    want = {1'b1, 7'h3C, 7'h64};
    step(1, 8'h90, 0, 1);
    step(1, 8'h3C, 0, 1);
    repeat (TIMEOUT - 1) step(0, 8'h00, 0, 1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_not_yet: got %b want 1", busy); end
    step(0, 8'h00, 0, 1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy_drop: got %b want 0", busy); end
    step(1, 8'h64, 0, 1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_no_event: got %b want 0", ev_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_new_d1: got %b want 1", busy); end
    // A byte arriving on the last count cycle still completes the message
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    repeat (TIMEOUT - 1) step(0, 8'h00, 0, 0);
    step(1, 8'h64, 0, 0);
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (got !== want || ev_valid !== 1'b1) begin n_bad++; $display("FAIL timeout_edge_event: got %b/%h want 1/%h", ev_valid, got, want); end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_byte_err();
    step(1, 8'h90, 0, 1);
    step(1, 8'h3C, 0, 1);
    step(0, 8'h00, 1, 1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL err_drop_partial: got %b want 0", busy); end
    step(1, 8'h64, 0, 1);
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL err_no_event: got %b want 0", ev_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL err_back_to_d1: got %b want 1", busy); end
    step(1, 8'h90, 0, 1);
    step(1, 8'h3C, 0, 1);
    step(1, 8'h64, 1, 1);
    n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL err_wins_valid: got %b/%b want 0/0", ev_valid, busy); end
  endtask

  task automatic test_fifo_pressure();
    logic [14:0] got;
    logic [14:0] want;
    int          pulses;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h90, 0, 0);
      if (overflow === 1'b1) pulses++;
      step(1, 8'(32'h30 + i), 0, 0);
      if (overflow === 1'b1) pulses++;
      step(1, 8'(32'h10 + i), 0, 0);
      if (overflow === 1'b1) pulses++;
      if (i == 4) begin
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
      end
    end
    step(0, 8'h00, 0, 0);
    if (overflow === 1'b1) pulses++;
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ovf_pulse_count: got %0d want 1", pulses); end
    for (int i = 0; i < 4; i++) begin
      want = {1'b1, 7'(32'h30 + i), 7'(32'h10 + i)};
      got  = {ev_on, ev_note, ev_vel};
      n_cmp++; if (got !== want || ev_valid !== 1'b1) begin n_bad++; $display("FAIL drain_order%0d: got %b/%h want 1/%h", i, ev_valid, got, want); end
      step(0, 8'h00, 0, 1);
    end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got;
    logic [14:0] last;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h80, 0, 0);
      step(1, 8'(32'h50 + i), 0, 0);
      step(1, 8'(32'h20 + i), 0, 0);
    end
    step(1, 8'h90, 0, 0);
    step(1, 8'h55, 0, 0);
    step(1, 8'h66, 0, 1);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overflow: got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      got = {ev_on, ev_note, ev_vel};
      n_cmp++; if (ev_valid !== 1'b1 || got !== exp_q[0]) begin n_bad++; $display("FAIL b2b_pop%0d: got %b/%h want 1/%h", i, ev_valid, got, exp_q[0]); end
      last = got;
      step(0, 8'h00, 0, 1);
    end
    n_cmp++; if (last !== {1'b1, 7'h55, 7'h66}) begin n_bad++; $display("FAIL b2b_tail: got %h want %h", last, {1'b1, 7'h55, 7'h66}); end
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", ev_valid); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    step(1, 8'h64, 0, 0);
    step(1, 8'h3D, 0, 0);
    step(1, 8'h65, 0, 0);
    step(1, 8'h90, 0, 0);
    step(1, 8'h3C, 0, 0);
    apply_reset();
    got = {ev_on, ev_note, ev_vel};
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", ev_valid); end
    n_cmp++; if (got !== 15'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state: got %h/%b want 0000/0", got, busy); end
    step(1, 8'h64, 0, 1);
    n_cmp++; if (ev_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle_discard: got %b/%b want 0/0", ev_valid, busy); end
  endtask

  task automatic test_random();
    logic [7:0]  bd;
    logic [3:0]  his [9];
    logic [14:0] got;
    bit          bv;
    bit          be;
    bit          rdy;
    bit          slow;
    int          r;
    his  = '{4'h8, 4'h9, 4'h9, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    slow = 0;
    for (int c = 0; c < 2000; c++) begin
      if ((c % 97) == 0) slow = ($urandom_range(0, 1) == 1);
      bv = 0;
      be = 0;
      bd = 8'h00;
      r  = $urandom_range(0, 99);
      if (r < 3) begin
        be = 1;
        bv = ($urandom_range(0, 1) == 1);
        bd = 8'($urandom_range(0, 255));
      end else if (r < 60) begin
        bv = 1;
        r  = $urandom_range(0, 19);
        if (r < 4) begin
          bd[7:4] = his[$urandom_range(0, 8)];
          bd[3:0] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'(CHANNEL);
        end else if (r == 4) begin
          bd = 8'($urandom_range(8'hF0, 8'hF7));
        end else if (r == 5) begin
          bd = 8'($urandom_range(8'hF8, 8'hFF));
        end else begin
          bd = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
        end
      end
      rdy = slow ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      step(bv, bd, be, rdy);
      got = {ev_on, ev_note, ev_vel};
      n_cmp++; if (ev_valid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, ev_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_cmp++; if (got !== exp_q[0]) begin n_bad++; $display("FAIL rnd_head c%0d: got %h want %h", c, got, exp_q[0]); end
      end
      n_cmp++; if (overflow !== exp_ovf) begin n_bad++; $display("FAIL rnd_overflow c%0d: got %b want %b", c, overflow, exp_ovf); end
      n_cmp++; if (busy !== (m_phase == 2)) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_phase == 2); end
    end
  endtask

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_err   = 1'b0;
    ev_ready   = 1'b0;
    model_reset();
    test_reset();
    test_note_on();
    test_running_status();
    test_filter_skip();
    test_realtime();
    test_timeout();
    test_byte_err();
    test_fifo_pressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
